mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the core's instruction-fetch interface and its data load/store interface.
- Sits between riscv_rv32i-style core ports and the memory model or SRAM wrapper.
- Arbitration is fixed-priority to data, with instruction-fetch starvation protection.
- Each transaction is serialised through a small FSM, and completion is returned to the requester that was granted.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_starve_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared opcodes and FSM state encodings for the unified-memory port arbiter.
// Also used by the core trace and the testbench.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_IFETCH,
      OP_DREAD,
      OP_DWRITE
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IFETCH,
      ST_DREAD,
      ST_DWRITE
   } arb_state_t;

   localparam logic [3:0] BYTE_EN_ALL = 4'hF;

   function automatic arb_state_t op_to_state(input mem_op_t op);
      arb_state_t st;
      case (op)
         OP_IFETCH: st = ST_IFETCH;
         OP_DREAD:  st = ST_DREAD;
         OP_DWRITE: st = ST_DWRITE;
         default:   st = ST_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the memory port of the arbiter.
// master is the arbiter's view; slave is the core/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_rdy;

   logic              d_re;
   logic              d_we;
   logic [3:0]        d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_rdy;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      input  if_req, if_addr,
      output if_rdata, if_rdy,
      input  d_re, d_we, d_be, d_addr, d_wdata,
      output d_rdata, d_rdy,
      output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      output if_req, if_addr,
      input  if_rdata, if_rdy,
      output d_re, d_we, d_be, d_addr, d_wdata,
      input  d_rdata, d_rdy,
      input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating wait counter for the fetch port; limit_hit flags that fetch
// has waited long enough to pre-empt data. STARVE_LIMIT=0 never hits.
module arb_starve_ctr #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt < LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign limit_hit = (STARVE_LIMIT != 0) && (cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter: data has priority, fetch is protected from
// starvation, and each access is serialised through IDLE -> granted -> IDLE.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int ADDR_W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus,
   output logic                proto_err
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   mem_op_t           grant;
   logic              limit_hit;
   logic              ack_if;
   logic              ack_d;
   logic              rd_d;
   logic              if_done;
   logic              d_done;
   logic [ADDR_W-1:0] grant_addr;

   // Arbitration only happens in IDLE; a starved fetch outranks data.
   always_comb begin
      grant = OP_NONE;
      if (state == ST_IDLE) begin
         if (bus.if_req && limit_hit) begin
            grant = OP_IFETCH;
         end else if (bus.d_we) begin
            grant = OP_DWRITE;
         end else if (bus.d_re) begin
            grant = OP_DREAD;
         end else if (bus.if_req) begin
            grant = OP_IFETCH;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ack_if    = 1'b0;
      ack_d     = 1'b0;
      rd_d      = 1'b0;
      case (state)
         ST_IDLE: state_nxt = op_to_state(grant);
         ST_IFETCH: begin
            ack_if = bus.mem_ack;
            if (bus.mem_ack) state_nxt = ST_IDLE;
         end
         ST_DREAD: begin
            ack_d = bus.mem_ack;
            rd_d  = 1'b1;
            if (bus.mem_ack) state_nxt = ST_IDLE;
         end
         ST_DWRITE: begin
            ack_d = bus.mem_ack;
            if (bus.mem_ack) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // An ack coinciding with reset belongs to an abandoned access.
   assign if_done      = ack_if && !rst;
   assign d_done       = ack_d && !rst;
   assign bus.if_rdy   = if_done;
   assign bus.if_rdata = if_done ? bus.mem_rdata : 32'h0;
   assign bus.d_rdy    = d_done;
   assign bus.d_rdata  = (d_done && rd_d) ? bus.mem_rdata : 32'h0;

   assign grant_addr = (grant == OP_IFETCH) ? bus.if_addr : bus.d_addr;

   // Memory request is captured on the grant edge and held until acked.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_addr  <= '0;
         bus.mem_re    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= 4'h0;
         bus.mem_wdata <= 32'h0;
      end else if (grant != OP_NONE) begin
         bus.mem_addr  <= grant_addr;
         bus.mem_re    <= (grant != OP_DWRITE);
         bus.mem_we    <= (grant == OP_DWRITE);
         bus.mem_be    <= (grant == OP_DWRITE) ? bus.d_be : BYTE_EN_ALL;
         bus.mem_wdata <= (grant == OP_DWRITE) ? bus.d_wdata : 32'h0;
      end else if ((state != ST_IDLE) && bus.mem_ack) begin
         bus.mem_addr  <= '0;
         bus.mem_re    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= 4'h0;
         bus.mem_wdata <= 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (bus.d_re && bus.d_we) begin
         proto_err <= 1'b1;
      end
   end

   arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (bus.if_req && ((grant == OP_DREAD) || (grant == OP_DWRITE))),
      .clr      (!bus.if_req || (grant == OP_IFETCH)),
      .limit_hit(limit_hit)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model checks each grant
// against queued expectations, a monitor checks every rdy pulse.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      logic        re;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
   } mem_exp_t;

   typedef struct {
      logic        is_if;
      logic [31:0] rdata;
   } cpl_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        proto_err;
   logic        ack_model;
   logic        ack_late;
   logic [31:0] model_rdata;
   logic [31:0] late_rdata;

   int vectors     = 0;
   int miscompares = 0;

   mem_exp_t mem_q[$];
   cpl_t     cpl_q[$];

   mem_port_arbiter_if #(.ADDR_W(32)) bus ();

   assign bus.mem_ack   = ack_model | ack_late;
   assign bus.mem_rdata = ack_late ? late_rdata : model_rdata;

   mem_port_arbiter #(
      .STARVE_LIMIT(2),
      .ADDR_W      (32)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_mem(input logic re, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdata);
      mem_exp_t e;
      e.re = re; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
      e.delay = delay; e.rdata = rdata;
      mem_q.push_back(e);
   endtask

   task automatic push_cpl(input logic is_if, input logic [31:0] rdata);
      cpl_t c;
      c.is_if = is_if; c.rdata = rdata;
      cpl_q.push_back(c);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Waits for the requester's rdy, then returns just after the edge that sees it.
   task automatic wait_rdy(input logic is_if, input int limit);
      int  n = 0;
      bit  seen = 0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         seen = is_if ? bus.if_rdy : bus.d_rdy;
      end
      if (!seen) check(is_if ? "if_rdy_timeout" : "d_rdy_timeout", 96'd0, 96'd1);
      @(posedge clk);
      #2;
   endtask

   // Memory model: accepts a new strobe, checks it and its stability, acks after delay.
   initial begin
      mem_exp_t cur;
      bit       active = 0;
      int       wait_cnt = 0;
      ack_model   = 1'b0;
      model_rdata = 32'h0;
      cur.re = 0; cur.we = 0; cur.addr = 0; cur.be = 0; cur.wdata = 0; cur.delay = 0; cur.rdata = 0;
      forever begin
         @(posedge clk);
         #1;
         ack_model   = 1'b0;
         model_rdata = 32'h0;
         if (active && !(bus.mem_re || bus.mem_we)) begin
            active = 0;
         end else if (active) begin
            check("mem_hold", {bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata},
                  {cur.re, cur.we, cur.addr, cur.be, cur.wdata});
         end
         if (!active && (bus.mem_re || bus.mem_we)) begin
            if (mem_q.size() == 0) begin
               check("unexpected_grant", {bus.mem_re, bus.mem_we, bus.mem_addr}, 96'd0);
               cur.re = bus.mem_re; cur.we = bus.mem_we; cur.addr = bus.mem_addr;
               cur.be = bus.mem_be; cur.wdata = bus.mem_wdata; cur.delay = 1; cur.rdata = 0;
            end else begin
               cur = mem_q.pop_front();
               check("mem_re",    bus.mem_re,    cur.re);
               check("mem_we",    bus.mem_we,    cur.we);
               check("mem_addr",  bus.mem_addr,  cur.addr);
               check("mem_be",    bus.mem_be,    cur.be);
               check("mem_wdata", bus.mem_wdata, cur.wdata);
            end
            active   = 1;
            wait_cnt = 0;
         end
         if (active) begin
            wait_cnt++;
            if (cur.delay != 0 && wait_cnt == cur.delay) begin
               ack_model   = 1'b1;
               model_rdata = cur.rdata;
            end
         end
      end
   end

   // Completion monitor.
   initial begin
      cpl_t c;
      forever begin
         @(negedge clk);
         if (bus.if_rdy || bus.d_rdy) begin
            if (cpl_q.size() == 0) begin
               check("unexpected_rdy", {bus.if_rdy, bus.d_rdy}, 96'd0);
            end else begin
               c = cpl_q.pop_front();
               check("rdy_port", {bus.if_rdy, bus.d_rdy}, {c.is_if, !c.is_if});
               check("rdata", c.is_if ? bus.if_rdata : bus.d_rdata, c.rdata);
               check("other_rdata", c.is_if ? bus.d_rdata : bus.if_rdata, 96'd0);
            end
         end else begin
            check("idle_rdata", {bus.if_rdata, bus.d_rdata}, 96'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      ack_late    = 1'b0;
      late_rdata  = 32'h0;
      bus.if_req  = 1'b0;
      bus.if_addr = 32'h0;
      bus.d_re    = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_be    = 4'h0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_re",    bus.mem_re,    96'd0);
      check("rst_mem_we",    bus.mem_we,    96'd0);
      check("rst_mem_addr",  bus.mem_addr,  96'd0);
      check("rst_mem_be",    bus.mem_be,    96'd0);
      check("rst_mem_wdata", bus.mem_wdata, 96'd0);
      check("rst_if_rdy",    bus.if_rdy,    96'd0);
      check("rst_d_rdy",     bus.d_rdy,     96'd0);
      check("rst_proto_err", proto_err,     96'd0);
      step(1);
      rst = 1'b0;
      step(1);

      // Lone fetch with an immediate ack: 2-cycle round trip.
      push_mem(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1, 32'h00000013);
      push_cpl(1'b1, 32'h00000013);
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      @(negedge clk);
      check("fetch_pre_grant_mem_re", bus.mem_re, 96'd0);
      @(negedge clk);
      check("fetch_mem_re",   bus.mem_re,   96'd1);
      check("fetch_mem_addr", bus.mem_addr, 96'h100);
      check("fetch_if_rdy",   bus.if_rdy,   96'd1);
      check("fetch_if_rdata", bus.if_rdata, 96'h13);
      @(posedge clk);
      #2;
      bus.if_req = 1'b0;
      step(2);

      // Byte-masked write, ack on the third strobe cycle.
      push_mem(1'b0, 1'b1, 32'h2004, 4'b0011, 32'hDEADBEEF, 3, 32'h0);
      push_cpl(1'b0, 32'h0);
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h2004;
      bus.d_be    = 4'b0011;
      bus.d_wdata = 32'hDEADBEEF;
      wait_rdy(1'b0, 20);
      bus.d_we = 1'b0;
      step(2);

      // Fetch and read together: read first, then the fetch.
      push_mem(1'b1, 1'b0, 32'h3000, 4'hF, 32'h0, 2, 32'hA5A5A5A5);
      push_mem(1'b1, 1'b0, 32'h104,  4'hF, 32'h0, 1, 32'h00100093);
      push_cpl(1'b0, 32'hA5A5A5A5);
      push_cpl(1'b1, 32'h00100093);
      fork
         begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h104;
            wait_rdy(1'b1, 40);
            bus.if_req = 1'b0;
         end
         begin
            bus.d_re   = 1'b1;
            bus.d_addr = 32'h3000;
            wait_rdy(1'b0, 40);
            bus.d_re = 1'b0;
         end
      join
      step(2);

      // Continuous reads with a waiting fetch: two reads, then the fetch wins.
      push_mem(1'b1, 1'b0, 32'h4000, 4'hF, 32'h0, 1, 32'h00000001);
      push_mem(1'b1, 1'b0, 32'h4004, 4'hF, 32'h0, 1, 32'h00000002);
      push_mem(1'b1, 1'b0, 32'h200,  4'hF, 32'h0, 1, 32'h00000033);
      push_mem(1'b1, 1'b0, 32'h4008, 4'hF, 32'h0, 1, 32'h00000003);
      push_cpl(1'b0, 32'h00000001);
      push_cpl(1'b0, 32'h00000002);
      push_cpl(1'b1, 32'h00000033);
      push_cpl(1'b0, 32'h00000003);
      fork
         begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h200;
            wait_rdy(1'b1, 60);
            bus.if_req = 1'b0;
         end
         begin
            bus.d_re   = 1'b1;
            bus.d_addr = 32'h4000;
            wait_rdy(1'b0, 60);
            bus.d_addr = 32'h4004;
            wait_rdy(1'b0, 60);
            bus.d_addr = 32'h4008;
            wait_rdy(1'b0, 60);
            bus.d_re = 1'b0;
         end
      join
      step(2);

      // Read and write together: write is served and the error sticks.
      push_mem(1'b0, 1'b1, 32'h5000, 4'hC, 32'h12345678, 2, 32'h0);
      push_cpl(1'b0, 32'h0);
      bus.d_re    = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h5000;
      bus.d_be    = 4'hC;
      bus.d_wdata = 32'h12345678;
      wait_rdy(1'b0, 20);
      bus.d_re = 1'b0;
      bus.d_we = 1'b0;
      step(3);
      @(negedge clk);
      check("proto_err_sticky", proto_err, 96'd1);
      step(1);

      // Reset during a read: access abandoned, acks around it ignored.
      push_mem(1'b1, 1'b0, 32'h6000, 4'hF, 32'h0, 0, 32'h0);
      bus.d_re   = 1'b1;
      bus.d_addr = 32'h6000;
      @(negedge clk);
      @(negedge clk);
      check("abort_mem_re_granted", bus.mem_re, 96'd1);
      @(posedge clk);
      #2;
      rst        = 1'b1;
      bus.d_re   = 1'b0;
      ack_late   = 1'b1;
      late_rdata = 32'h00000BAD;
      @(negedge clk);
      check("abort_ack_with_rst_d_rdy", bus.d_rdy, 96'd0);
      @(posedge clk);
      #2;
      rst      = 1'b0;
      ack_late = 1'b0;
      @(negedge clk);
      check("abort_mem_re_dropped", bus.mem_re, 96'd0);
      check("abort_proto_err_clear", proto_err, 96'd0);
      @(posedge clk);
      #2;
      ack_late = 1'b1;
      @(negedge clk);
      check("late_ack_d_rdy",  bus.d_rdy,  96'd0);
      check("late_ack_if_rdy", bus.if_rdy, 96'd0);
      @(posedge clk);
      #2;
      ack_late = 1'b0;
      step(2);
      @(negedge clk);
      check("late_ack_still_idle", {bus.mem_re, bus.mem_we}, 96'd0);

      step(3);
      check("mem_q_drained", mem_q.size(), 96'd0);
      check("cpl_q_drained", cpl_q.size(), 96'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
